// File: rtl/acc_sum_differ_pkg.sv
// acc_sum_differ_pkg: shared state type, FIFO depth and delta arithmetic.
// ACC_SUM_DIFFER_SAT_EN selects the saturating signed subtraction.
package acc_sum_differ_pkg;

  typedef enum logic {PRIME, RUN} state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_W      = 64;

  typedef logic [MAX_W-1:0]        word_t;
  typedef logic signed [MAX_W:0]   sword_t;

  typedef struct packed {
    logic  ovf;
    word_t val;
  } calc_t;

  // Operands are zero-extended w-bit values; only val[w-1:0] is meaningful.
  function automatic calc_t delta_calc(
    input word_t       s,
    input word_t       p,
    input int unsigned w
  );
    calc_t       r;
    word_t       mask;
`ifdef ACC_SUM_DIFFER_SAT_EN
    int unsigned sh;
    logic signed [MAX_W-1:0] ts;
    logic signed [MAX_W-1:0] tp;
    sword_t      sx;
    sword_t      px;
    sword_t      d;
    sword_t      hi;
    sword_t      lo;
`endif
    if (w >= MAX_W) mask = '1;
    else mask = (word_t'(1) << w) - word_t'(1);
    r.ovf = 1'b0;
    r.val = (s - p) & mask;
`ifdef ACC_SUM_DIFFER_SAT_EN
    sh = MAX_W - w;
    ts = signed'(s << sh);
    tp = signed'(p << sh);
    sx = {ts[MAX_W-1], ts};
    px = {tp[MAX_W-1], tp};
    sx = sx >>> sh;
    px = px >>> sh;
    d  = sx - px;
    hi = (sword_t'(1) <<< (w - 1)) - sword_t'(1);
    lo = -(sword_t'(1) <<< (w - 1));
    if (d > hi) begin
      r.ovf = 1'b1;
      r.val = hi[MAX_W-1:0] & mask;
    end else if (d < lo) begin
      r.ovf = 1'b1;
      r.val = lo[MAX_W-1:0] & mask;
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/acc_skid_fifo.sv
// acc_skid_fifo: 2-entry valid/ready FIFO with synchronous clear.
// Head is registered; a push into an empty FIFO shows up next cycle.
module acc_skid_fifo
  import acc_sum_differ_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [W-1:0] slot0_nxt;
  logic [W-1:0] slot1_nxt;
  logic         push;
  logic         pop;

  assign push_ready = (count < 2'(FIFO_DEPTH));
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = slot0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_comb begin
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    count_nxt = count;
    if (pop) begin
      slot0_nxt = slot1;
      count_nxt = count - 2'd1;
    end
    if (push) begin
      if (count_nxt == 2'd0) slot0_nxt = push_data;
      else slot1_nxt = push_data;
      count_nxt = count_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      count <= count_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

endmodule

// File: rtl/acc_sum_differ.sv
// acc_sum_differ: recovers per-cycle increments from a running-sum stream.
// ACC_SUM_DIFFER_SAT_EN enables signed saturation and the sticky ovf flag.
module acc_sum_differ
  import acc_sum_differ_pkg::*;
#(
  parameter int           W          = 8,
  parameter logic [W-1:0] INIT_SUM   = '0,
  parameter int           EMIT_FIRST = 1,
  parameter int           CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          sum_valid,
  output logic          sum_ready,
  input  logic [W-1:0]  sum,
  output logic          delta_valid,
  input  logic          delta_ready,
  output logic [W-1:0]  delta,
  output logic          delta_neg,
  output logic [CW-1:0] delta_cnt,
  output logic          ovf
);

  state_e        state;
  state_e        state_nxt;
  logic [W-1:0]  prev_sum;
  logic [W-1:0]  prev_nxt;
  logic [W-1:0]  ref_sum;
  logic [W-1:0]  push_data;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          push;
  logic          fifo_ready;
  calc_t         calc;
  logic          calc_unused;

  assign sum_ready = fifo_ready;
  assign accept    = sum_valid && sum_ready;
  assign ref_sum   = (state == PRIME) ? INIT_SUM : prev_sum;
  assign calc      = delta_calc(word_t'(sum), word_t'(ref_sum), W);
  assign push_data = calc.val[W-1:0];
  assign delta_neg = delta[W-1];
  assign delta_cnt = cnt;

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_sum;
    push      = 1'b0;
    if (clr) begin
      state_nxt = PRIME;
      prev_nxt  = INIT_SUM;
    end else if (accept) begin
      state_nxt = RUN;
      prev_nxt  = sum;
      push      = (state == RUN) || (EMIT_FIRST != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIME;
      prev_sum <= INIT_SUM;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      prev_sum <= prev_nxt;
      if (clr) cnt <= '0;
      else if (push) cnt <= cnt + 1'b1;
    end
  end

`ifdef ACC_SUM_DIFFER_SAT_EN
  logic ovf_r;

  always_ff @(posedge clk) begin
    if (rst || clr) ovf_r <= 1'b0;
    else if (push && calc.ovf) ovf_r <= 1'b1;
  end

  assign ovf         = ovf_r;
  assign calc_unused = ^calc.val[MAX_W-1:W];
`else
  assign ovf         = 1'b0;
  assign calc_unused = ^{calc.ovf, calc.val[MAX_W-1:W]};
`endif

  acc_skid_fifo #(
    .W (W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .push_valid (push),
    .push_ready (fifo_ready),
    .push_data  (push_data),
    .pop_valid  (delta_valid),
    .pop_ready  (delta_ready),
    .pop_data   (delta)
  );

endmodule

// File: tb/tb_acc_sum_differ.sv
// tb_acc_sum_differ: directed stimulus, queue-based reference model,
// per-cycle compare plus literal checks. Honours ACC_SUM_DIFFER_SAT_EN.
module tb_acc_sum_differ;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        sum_valid;
  logic        sum_ready;
  logic [7:0]  sum;
  logic        delta_valid;
  logic        delta_ready;
  logic [7:0]  delta;
  logic        delta_neg;
  logic [15:0] delta_cnt;
  logic        ovf;

  logic        sv2;
  logic        sr2;
  logic [7:0]  s2;
  logic        dv2;
  logic        dr2;
  logic [7:0]  d2;
  logic        dn2;
  logic [15:0] dc2;
  logic        ov2;

  int n_cmp;
  int n_bad;

  logic [7:0]  q[$];
  logic [15:0] mcnt;
  logic        movf;
  logic        primed;
  logic [7:0]  prev;

  acc_sum_differ u_dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .sum         (sum),
    .delta_valid (delta_valid),
    .delta_ready (delta_ready),
    .delta       (delta),
    .delta_neg   (delta_neg),
    .delta_cnt   (delta_cnt),
    .ovf         (ovf)
  );

  acc_sum_differ #(
    .INIT_SUM   (8'h20),
    .EMIT_FIRST (0)
  ) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .clr         (1'b0),
    .sum_valid   (sv2),
    .sum_ready   (sr2),
    .sum         (s2),
    .delta_valid (dv2),
    .delta_ready (dr2),
    .delta       (d2),
    .delta_neg   (dn2),
    .delta_cnt   (dc2),
    .ovf         (ov2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mdelta(input logic [7:0] s,
                                        input logic [7:0] p,
                                        output bit o);
`ifdef ACC_SUM_DIFFER_SAT_EN
    int d;
    o = 1'b0;
    d = int'($signed(s)) - int'($signed(p));
    if (d > 127) begin
      o = 1'b1;
      return 8'h7F;
    end
    if (d < -128) begin
      o = 1'b1;
      return 8'h80;
    end
    return 8'(d);
`else
    o = 1'b0;
    return s - p;
`endif
  endfunction

  // Reference model: deltas are what the stream rules say, FIFO is a queue.
  always @(posedge clk) begin : model
    bit         acc;
    bit         pop;
    bit         o;
    logic [7:0] d;
    acc = sum_valid && (q.size() < 2);
    pop = delta_ready && (q.size() != 0);
    if (rst) begin
      q.delete();
      mcnt   = 16'd0;
      movf   = 1'b0;
      primed = 1'b0;
      prev   = 8'h00;
    end else begin
      if (pop) void'(q.pop_front());
      if (clr) begin
        q.delete();
        mcnt   = 16'd0;
        movf   = 1'b0;
        primed = 1'b0;
        prev   = 8'h00;
      end else if (acc) begin
        d = mdelta(sum, primed ? prev : 8'h00, o);
        q.push_back(d);
        mcnt = mcnt + 16'd1;
        if (o) movf = 1'b1;
        prev   = sum;
        primed = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_valid", 32'(delta_valid), 32'(q.size() != 0));
      chk("m_ready", 32'(sum_ready), 32'(q.size() < 2));
      chk("m_cnt", 32'(delta_cnt), 32'(mcnt));
      chk("m_ovf", 32'(ovf), 32'(movf));
      if (q.size() != 0) begin
        chk("m_delta", 32'(delta), 32'(q[0]));
        chk("m_neg", 32'(delta_neg), 32'(q[0][7]));
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    clr         = 1'b0;
    sum_valid   = 1'b0;
    sum         = 8'h00;
    delta_ready = 1'b1;
    sv2         = 1'b0;
    s2          = 8'h00;
    dr2         = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(delta_valid), 32'd0);
    chk("rst_delta", 32'(delta), 32'd0);
    chk("rst_neg", 32'(delta_neg), 32'd0);
    chk("rst_cnt", 32'(delta_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(sum_ready), 32'd1);

    // basic stream
    sum_valid = 1'b1;
    sum = 8'h03;
    tick();
    chk("b_d0", 32'(delta), 32'h03);
    chk("b_v0", 32'(delta_valid), 32'd1);
    sum = 8'h07;
    tick();
    chk("b_d1", 32'(delta), 32'h04);
    sum = 8'h0C;
    tick();
    chk("b_d2", 32'(delta), 32'h05);
    chk("b_cnt", 32'(delta_cnt), 32'd3);
    sum_valid = 1'b0;
    tick();
    chk("b_empty", 32'(delta_valid), 32'd0);

    // wrap-around
    sum_valid = 1'b1;
    sum = 8'hFB;
    tick();
    chk("w_d0", 32'(delta), 32'hEF);
    chk("w_n0", 32'(delta_neg), 32'd1);
    sum = 8'h05;
    tick();
    chk("w_d1", 32'(delta), 32'h0A);
    chk("w_n1", 32'(delta_neg), 32'd0);
    sum = 8'h7E;
    tick();
    chk("w_d2", 32'(delta), 32'h79);
    sum = 8'h82;
    tick();
`ifndef ACC_SUM_DIFFER_SAT_EN
    chk("w_d3", 32'(delta), 32'h04);
`endif
    sum_valid = 1'b0;
    tick();

    // backpressure
    clr = 1'b1;
    tick();
    clr = 1'b0;
    delta_ready = 1'b0;
    sum_valid = 1'b1;
    sum = 8'h10;
    tick();
    sum = 8'h11;
    tick();
    chk("bp_rdy_lo", 32'(sum_ready), 32'd0);
    sum = 8'h13;
    tick();
    tick();
    chk("bp_head", 32'(delta), 32'h10);
    chk("bp_cnt2", 32'(delta_cnt), 32'd2);
    delta_ready = 1'b1;
    tick();
    chk("bp_pop1", 32'(delta), 32'h01);
    chk("bp_cnt2b", 32'(delta_cnt), 32'd2);
    tick();
    chk("bp_pop2", 32'(delta), 32'h02);
    sum = 8'h16;
    tick();
    chk("bp_pop3", 32'(delta), 32'h03);
    chk("bp_cnt4", 32'(delta_cnt), 32'd4);
    sum_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(delta_valid), 32'd0);

    // clear mid-stream
    delta_ready = 1'b0;
    sum_valid = 1'b1;
    sum = 8'h20;
    tick();
    sum = 8'h21;
    tick();
    chk("c_full", 32'(sum_ready), 32'd0);
    clr = 1'b1;
    sum = 8'h99;
    tick();
    clr = 1'b0;
    sum_valid = 1'b0;
    chk("c_valid", 32'(delta_valid), 32'd0);
    chk("c_cnt", 32'(delta_cnt), 32'd0);
    chk("c_ready", 32'(sum_ready), 32'd1);
    delta_ready = 1'b1;
    sum_valid = 1'b1;
    sum = 8'h10;
    tick();
    chk("c_prime", 32'(delta), 32'h10);
    chk("c_cnt1", 32'(delta_cnt), 32'd1);
    sum_valid = 1'b0;
    tick();

    // reset mid-stream, with clr asserted too
    delta_ready = 1'b0;
    sum_valid = 1'b1;
    sum = 8'h40;
    tick();
    sum = 8'h45;
    tick();
    rst = 1'b1;
    clr = 1'b1;
    sum_valid = 1'b0;
    tick();
    chk("r_valid", 32'(delta_valid), 32'd0);
    chk("r_delta", 32'(delta), 32'd0);
    chk("r_cnt", 32'(delta_cnt), 32'd0);
    rst = 1'b0;
    clr = 1'b0;
    tick();
    delta_ready = 1'b1;
    sum_valid = 1'b1;
    sum = 8'h07;
    tick();
    chk("r_prime", 32'(delta), 32'h07);
    sum_valid = 1'b0;
    tick();

`ifdef ACC_SUM_DIFFER_SAT_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sum_valid = 1'b1;
    sum = 8'h7F;
    tick();
    chk("s_d0", 32'(delta), 32'h7F);
    chk("s_ovf0", 32'(ovf), 32'd0);
    sum = 8'h80;
    tick();
    chk("s_d1", 32'(delta), 32'h80);
    chk("s_ovf1", 32'(ovf), 32'd1);
    sum_valid = 1'b0;
    tick();
    tick();
    chk("s_hold", 32'(ovf), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s_clr", 32'(ovf), 32'd0);
    tick();
`endif

    // no-emit-first instance, INIT_SUM=0x20
    sv2 = 1'b1;
    s2 = 8'h25;
    tick();
    chk("e_v0", 32'(dv2), 32'd0);
    chk("e_c0", 32'(dc2), 32'd0);
    s2 = 8'h30;
    tick();
    chk("e_v1", 32'(dv2), 32'd1);
    chk("e_d1", 32'(d2), 32'h0B);
    chk("e_c1", 32'(dc2), 32'd1);
    sv2 = 1'b0;
    tick();
    chk("e_v2", 32'(dv2), 32'd0);
    chk("e_c2", 32'(dc2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
